// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants: reset PC, offset field widths, FSM states.
package fetch_stage_pkg;

  localparam int PC_W     = 16;
  localparam int BR_OFF_W = 6;
  localparam int J_OFF_W  = 12;

  localparam logic [PC_W-1:0] RESET_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_BUBBLE = 2'd1,
    S_HALT   = 2'd2
  } fsm_e;

endpackage

// File: rtl/fetch_stage_pc_target_calc.sv
// Branch and jump target arithmetic relative to the IF/ID PC + 2.
module pc_target_calc
  import fetch_stage_pkg::*;
(
  input  logic [PC_W-1:0]     ifid_pc_plus2,
  input  logic [BR_OFF_W-1:0] branch_offset,
  input  logic [J_OFF_W-1:0]  jump_offset,
  output logic [PC_W-1:0]     branch_target,
  output logic [PC_W-1:0]     jump_target
);

  logic [PC_W-1:0] br_disp;

  // Word offset -> sign-extended byte displacement.
  assign br_disp = {{(PC_W-BR_OFF_W-1){branch_offset[BR_OFF_W-1]}},
                    branch_offset, 1'b0};

  assign branch_target = ifid_pc_plus2 + br_disp;
  assign jump_target   = {ifid_pc_plus2[PC_W-1:J_OFF_W+1],
                          jump_offset, 1'b0};

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/ID latch, redirect flush and halt FSM.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                halt,
  input  logic                branch_taken,
  input  logic [BR_OFF_W-1:0] branch_offset,
  input  logic                jump,
  input  logic [J_OFF_W-1:0]  jump_offset,
  input  logic [PC_W-1:0]     instruction,
  output logic [PC_W-1:0]     pc,
  output logic [PC_W-1:0]     ifid_instr,
  output logic [PC_W-1:0]     ifid_pc_plus2,
  output logic                ifid_valid,
  output logic                halted
);

  fsm_e            state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] instr_q;
  logic [PC_W-1:0] pp2_q;
  logic            valid_q;
  logic            halted_q;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] j_tgt;
  logic [PC_W-1:0] redir_tgt;
  logic            redirect;

  pc_target_calc u_tgt (
    .ifid_pc_plus2 (pp2_q),
    .branch_offset (branch_offset),
    .jump_offset   (jump_offset),
    .branch_target (br_tgt),
    .jump_target   (j_tgt)
  );

  assign pc_inc    = pc_q + 16'd2;
  assign redirect  = valid_q & (jump | branch_taken);
  assign redir_tgt = jump ? j_tgt : br_tgt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      pc_q     <= {RESET_PC[PC_W-1:1], 1'b0};
      instr_q  <= '0;
      pp2_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_HALT: state_q <= S_HALT;
        default: begin
          if (halt) begin
            state_q  <= S_HALT;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
          end else if (redirect) begin
            state_q <= S_BUBBLE;
            pc_q    <= {redir_tgt[PC_W-1:1], 1'b0};
            valid_q <= 1'b0;
          end else if (stall) begin
            // A bubble lasts one cycle even while stalled.
            state_q <= S_RUN;
          end else begin
            state_q <= S_RUN;
            instr_q <= instruction;
            pp2_q   <= pc_inc;
            valid_q <= 1'b1;
            pc_q    <= {pc_inc[PC_W-1:1], 1'b0};
          end
        end
      endcase
    end
  end

  assign pc            = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus2 = pp2_q;
  assign ifid_valid    = valid_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage against a rule-level model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, halt, branch_taken, jump;
  logic [5:0]  branch_offset;
  logic [11:0] jump_offset;
  logic [15:0] instruction;
  logic [15:0] pc, ifid_instr, ifid_pc_plus2;
  logic        ifid_valid, halted;

  logic [15:0] mem [32768];

  int vecs = 0;
  int errs = 0;

  logic [15:0] m_pc, m_instr, m_pp2;
  logic        m_valid, m_halt, m_known;

  always #5 clk = ~clk;

  assign instruction = mem[pc[15:1]];

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .halt          (halt),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_offset   (jump_offset),
    .instruction   (instruction),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus2 (ifid_pc_plus2),
    .ifid_valid    (ifid_valid),
    .halted        (halted)
  );

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 0; stall = 0; halt = 0;
    branch_taken = 0; jump = 0;
    branch_offset = '0; jump_offset = '0;
  endtask

  task automatic step();
    int tgt;
    if (rst) begin
      m_pc = 16'h0000; m_instr = '0; m_pp2 = '0;
      m_valid = 0; m_halt = 0; m_known = 1;
    end else if (m_halt) begin
    end else if (halt) begin
      m_halt = 1; m_valid = 0; m_known = 0;
    end else if (m_valid && jump) begin
      m_pc = {m_pp2[15:13], jump_offset, 1'b0};
      m_valid = 0; m_known = 0;
    end else if (m_valid && branch_taken) begin
      tgt = int'(m_pp2) + 2 * int'($signed(branch_offset));
      m_pc = 16'(tgt);
      m_valid = 0; m_known = 0;
    end else if (stall) begin
    end else begin
      m_instr = mem[m_pc[15:1]];
      m_pp2 = m_pc + 16'd2;
      m_pc = m_pc + 16'd2;
      m_valid = 1; m_known = 1;
    end
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("ifid_valid", 16'(ifid_valid), 16'(m_valid));
    chk("halted", 16'(halted), 16'(m_halt));
    if (m_known) begin
      chk("ifid_instr", ifid_instr, m_instr);
      chk("ifid_pc_plus2", ifid_pc_plus2, m_pp2);
    end
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  task automatic hop();
    jump = 1; jump_offset = 12'hFFF; step();
    jump = 0; step();
  endtask

  logic [15:0] held;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    idle();
    m_pc = 'x; m_instr = 'x; m_pp2 = 'x;
    m_valid = 0; m_halt = 0; m_known = 0;

    // reset and free-run
    do_reset();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_valid", 16'(ifid_valid), 16'h0);
    chk("rst_pp2", ifid_pc_plus2, 16'h0000);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("run_pc", pc, 16'(2 * k));
      chk("run_pp2", ifid_pc_plus2, 16'(2 * k));
      chk("run_valid", 16'(ifid_valid), 16'h1);
    end

    // backward branch then ignored branch in bubble
    do_reset();
    repeat (3) step();
    chk("br_pp2", ifid_pc_plus2, 16'h0006);
    branch_taken = 1; branch_offset = 6'b111110; step();
    chk("br_pc", pc, 16'h0002);
    chk("br_bubble", 16'(ifid_valid), 16'h0);
    branch_offset = 6'b010101; step();
    chk("br_ign_pc", pc, 16'h0004);
    chk("br_instr", ifid_instr, mem[1]);
    chk("br_valid", 16'(ifid_valid), 16'h1);
    idle();

    // stall hold, then stall + branch
    held = pc;
    stall = 1;
    repeat (3) step();
    chk("stall_pc", pc, held);
    branch_taken = 1; branch_offset = 6'd2; step();
    chk("stall_br_pc", pc, 16'h0008);
    chk("stall_br_valid", 16'(ifid_valid), 16'h0);
    idle(); step();

    // hop to region 0xA000 and jump
    repeat (5) hop();
    repeat (2) step();
    chk("j_pp2", ifid_pc_plus2, 16'hA004);
    jump = 1; jump_offset = 12'h010; step();
    chk("j_pc", pc, 16'hA020);
    idle(); step();
    jump = 1; jump_offset = 12'h020;
    branch_taken = 1; branch_offset = 6'd1; step();
    chk("jb_pc", pc, 16'hA040);
    idle(); step();

    // wrap at 0xFFFE
    repeat (2) hop();
    jump = 1; jump_offset = 12'hFFF; step();
    chk("wrap_pre", pc, 16'hFFFE);
    idle(); step();
    chk("wrap_pc", pc, 16'h0000);
    chk("wrap_pp2", ifid_pc_plus2, 16'h0000);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      halt = ($urandom_range(0, 79) == 0);
      stall = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 3) == 0);
      jump = ($urandom_range(0, 5) == 0);
      branch_offset = 6'($urandom);
      jump_offset = 12'($urandom);
      step();
    end

    // halt and recovery
    do_reset();
    repeat (3) step();
    halt = 1; step(); halt = 0;
    held = pc;
    for (int k = 0; k < 10; k++) begin
      stall = 1'($urandom); jump = 1'($urandom);
      step();
      chk("halt_pc", pc, held);
      chk("halt_flag", 16'(halted), 16'h1);
      chk("halt_valid", 16'(ifid_valid), 16'h0);
    end
    do_reset();
    chk("unhalt_pc", pc, 16'h0000);
    chk("unhalt_flag", 16'(halted), 16'h0);
    step();
    chk("first_valid", 16'(ifid_valid), 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port stall, input, 1, hazard hold of PC and IF/ID.
REQ-005 The block SHALL have port halt, input, 1, halt request from decode.
REQ-006 The block SHALL have port branch_taken, input, 1, resolved branch for the IF/ID instruction.
REQ-007 The block SHALL have port branch_offset, input, 6, signed word offset (instr[5:0]).
REQ-008 The block SHALL have port jump, input, 1, jump for the IF/ID instruction.
REQ-009 The block SHALL have port jump_offset, input, 12, word target field (instr[11:0]).
REQ-010 The block SHALL have port instruction, input, 16, instruction-memory read data for pc.
REQ-011 The block SHALL have port pc, output, 16, byte address to instruction memory.
REQ-012 The block SHALL have port ifid_instr, output, 16, registered instruction.
REQ-013 The block SHALL have port ifid_pc_plus2, output, 16, registered fetch PC + 2.
REQ-014 The block SHALL have port ifid_valid, output, 1, the IF/ID contents are a real instruction.
REQ-015 The block SHALL have port halted, output, 1, the FSM is in HALT.

Function
REQ-016 The FSM SHALL have states RUN, BUBBLE and HALT.
REQ-017 pc SHALL be a register, always even; pc[0] SHALL be held 0.
REQ-018 Sequential next PC SHALL be pc + 2, mod 2^16; 16'hFFFE SHALL wrap to 16'h0000.
REQ-019 Branch target SHALL be ifid_pc_plus2 + {sext(branch_offset), 1'b0}, mod 2^16.
REQ-020 Jump target SHALL be {ifid_pc_plus2[15:13], jump_offset, 1'b0}.
REQ-021 Redirects SHALL apply only when ifid_valid=1; with ifid_valid=0, jump and branch_taken SHALL be ignored.
REQ-022 Update priority per cycle SHALL be: rst > halt > jump > branch_taken > stall > sequential.
REQ-023 On a redirect, pc SHALL load the target, ifid_valid SHALL clear next cycle, and the FSM SHALL enter BUBBLE.
REQ-024 This flush SHALL make one bubble cycle per taken redirect.
REQ-025 A redirect SHALL win over a simultaneous stall.
REQ-026 BUBBLE SHALL return to RUN after one cycle and fetch sequentially unless stall or a new redirect applies.
REQ-027 In RUN with no redirect and no stall, IF/ID SHALL capture instruction and pc+2, ifid_valid SHALL be 1, and pc SHALL advance.
REQ-028 With stall=1 and no redirect, pc, ifid_instr, ifid_pc_plus2 and ifid_valid SHALL hold.
REQ-029 halt=1 SHALL enter HALT next cycle, freeze pc, clear ifid_valid and set halted=1.
REQ-030 HALT SHALL be left only by rst.
REQ-031 Fetch latency SHALL be one cycle from pc to ifid_instr, with instruction combinational from memory.

Reset
REQ-032 On rst=1 at a clock edge: pc = RESET_PC, ifid_instr = 16'h0000, ifid_pc_plus2 = 16'h0000, ifid_valid = 0, halted = 0, FSM = RUN.
REQ-033 Reset mid-redirect or mid-stall SHALL discard the pending operation.
REQ-034 The first valid IF/ID SHALL appear one cycle after rst deasserts.

Structure
REQ-035 RESET_PC default, state encodings and field widths (6, 12) SHALL live in shared Parameter.v.
REQ-036 Target arithmetic SHALL be the combinational sub-module pc_target_calc (inputs ifid_pc_plus2, branch_offset, jump_offset; outputs branch_target, jump_target).

Verification
REQ-037 Reset, 5 cycles free-run over memory words 0..4 -> pc 0,2,4,6,8; ifid_pc_plus2 2,4,6,8; ifid_valid 1 from cycle 1.
REQ-038 IF/ID at pc_plus2=16'h0006, branch_taken=1, offset=6'b111110 -> pc=16'h0002, one ifid_valid=0 cycle, then instr@0x0002.
REQ-039 Jump with ifid_pc_plus2=16'hA004, jump_offset=12'h010 -> pc=16'hA020; jump+branch_taken together -> jump target wins.
REQ-040 stall=1 for 3 cycles -> all outputs frozen; stall+branch_taken same cycle -> redirect taken, bubble inserted.
REQ-041 pc=16'hFFFE, sequential -> pc=16'h0000; branch_taken with ifid_valid=0 -> ignored.
REQ-042 halt=1 -> halted=1, pc frozen 10 cycles, ifid_valid=0; rst -> pc=RESET_PC, halted=0.
